// File: rtl/pci_burst_target.sv
// rtl/pci_burst_target.sv - PCI memory target with burst, byte enables, disconnect at window end
// Optional macro PARITY_EN adds the Par/par_oe outputs and read-data parity generation.
module pci_burst_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0010,
    parameter int          DEPTH       = 8,
    parameter int          DEVSEL_DLY  = 0,
    parameter int          WAIT_STATES = 0
) (
    input  logic        Clock,
    input  logic        RST,
    input  logic        Frame,
    input  logic        Irdy,
    input  logic [3:0]  CBE,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        Devsel,
    output logic        Trdy,
`ifdef PARITY_EN
    output logic        Par,
    output logic        par_oe,
`endif
    output logic        Stop
);

    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
    // Cycle offsets after the address edge: Devsel, first write Trdy, first read Trdy
    localparam logic [7:0]      DEV_OFF = 8'(1 + DEVSEL_DLY);
    localparam logic [7:0]      WR_OFF  = 8'(1 + DEVSEL_DLY + WAIT_STATES);
    localparam logic [7:0]      RD_OFF  = (WR_OFF < 8'd2) ? 8'd2 : WR_OFF;
    localparam logic [32:0]     WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0]     WIN_HI  = WIN_LO + 33'(4 * DEPTH);

    typedef enum logic [2:0] {IDLE, ADDR_WAIT, DATA, DISC, TURN} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] ptr;
    logic          is_read;
    logic          bus_idle;
    logic [7:0]    cyc;

    logic          hit;
    logic [7:0]    cyc_next;
    logic [31:0]   next_word;
    logic [31:0]   wr_word;

    // Address decode, next read word and byte-merged write word
    always_comb begin
        hit       = ({1'b0, ad_in} >= WIN_LO) && ({1'b0, ad_in} < WIN_HI) && (CBE[3:1] == 3'b011);
        cyc_next  = (cyc == 8'hFF) ? cyc : cyc + 8'd1;
        next_word = (ptr == LAST) ? mem[ptr] : mem[ptr + PW'(1)];
        wr_word   = mem[ptr];
        for (int i = 0; i < 4; i++) begin
            if (!CBE[i]) wr_word[8*i +: 8] = ad_in[8*i +: 8];
        end
    end

    // Transaction FSM with registered bus outputs and memory writes
    always_ff @(posedge Clock) begin
        if (RST) begin
            state    <= IDLE;
            Devsel   <= 1'b1;
            Trdy     <= 1'b1;
            Stop     <= 1'b1;
            ad_oe    <= 1'b0;
            ad_out   <= '0;
            ptr      <= '0;
            is_read  <= 1'b0;
            bus_idle <= 1'b0;
            cyc      <= '0;
`ifdef PARITY_EN
            Par      <= 1'b0;
            par_oe   <= 1'b0;
`endif
        end else begin
            bus_idle <= Frame & Irdy;
            case (state)
                IDLE: begin
                    if (!Frame && bus_idle && hit) begin
                        ptr     <= PW'((ad_in - BASE_ADDR) >> 2);
                        is_read <= !CBE[0];
                        cyc     <= 8'd1;
                        Devsel  <= (DEV_OFF == 8'd1) ? 1'b0 : 1'b1;
                        if (CBE[0] && (WR_OFF == 8'd1)) begin
                            state <= DATA;
                            Trdy  <= 1'b0;
                        end else begin
                            state <= ADDR_WAIT;
                        end
                    end
                end
                ADDR_WAIT: begin
                    cyc <= cyc_next;
                    if (cyc_next >= DEV_OFF) Devsel <= 1'b0;
                    if (is_read) begin
                        ad_oe  <= 1'b1;
                        ad_out <= mem[ptr];
                    end
`ifdef PARITY_EN
                    if (is_read && cyc >= 8'd2) par_oe <= 1'b1;
`endif
                    if (cyc_next == (is_read ? RD_OFF : WR_OFF)) begin
                        state <= DATA;
                        Trdy  <= 1'b0;
                    end
                end
                DATA: begin
                    cyc <= cyc_next;
`ifdef PARITY_EN
                    if (is_read && cyc >= 8'd2) par_oe <= 1'b1;
`endif
                    if (!Irdy) begin
                        ptr <= ptr + PW'(1);
                        if (is_read) begin
                            ad_out <= next_word;
`ifdef PARITY_EN
                            Par    <= ^{ad_out, CBE};
                            par_oe <= 1'b1;
`endif
                        end else begin
                            mem[ptr] <= wr_word;
                        end
                        if (Frame) begin
                            state  <= TURN;
                            Devsel <= 1'b1;
                            Trdy   <= 1'b1;
                            Stop   <= 1'b1;
                            ad_oe  <= 1'b0;
                        end else if (ptr == LAST) begin
                            state <= DISC;
                            Trdy  <= 1'b1;
                            Stop  <= 1'b0;
                        end
                    end
                end
                DISC: begin
`ifdef PARITY_EN
                    par_oe <= 1'b0;
`endif
                    if (Frame) begin
                        state  <= TURN;
                        Devsel <= 1'b1;
                        Trdy   <= 1'b1;
                        Stop   <= 1'b1;
                        ad_oe  <= 1'b0;
                    end
                end
                TURN: begin
`ifdef PARITY_EN
                    par_oe <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_burst_target.sv
// tb/tb_pci_burst_target.sv - directed and randomized bench for pci_burst_target
module tb_pci_burst_target;

    logic        Clock = 1'b0;
    logic        RST, Frame, Irdy;
    logic [3:0]  CBE;
    logic [31:0] ad_in;
    logic [31:0] ad_out, s_ad_out;
    logic        ad_oe, Devsel, Trdy, Stop;
    logic        s_ad_oe, s_Devsel, s_Trdy, s_Stop;
`ifdef PARITY_EN
    logic        Par, par_oe, s_Par, s_par_oe;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [8];
    logic [31:0] wd [16];
    logic [3:0]  bv [16];
    logic [31:0] last_rd;

    always #5 Clock = ~Clock;

    pci_burst_target dut (
        .Clock(Clock), .RST(RST), .Frame(Frame), .Irdy(Irdy), .CBE(CBE), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .Devsel(Devsel), .Trdy(Trdy),
`ifdef PARITY_EN
        .Par(Par), .par_oe(par_oe),
`endif
        .Stop(Stop)
    );

    pci_burst_target #(.DEVSEL_DLY(2), .WAIT_STATES(1)) dut_slow (
        .Clock(Clock), .RST(RST), .Frame(Frame), .Irdy(Irdy), .CBE(CBE), .ad_in(ad_in),
        .ad_out(s_ad_out), .ad_oe(s_ad_oe), .Devsel(s_Devsel), .Trdy(s_Trdy),
`ifdef PARITY_EN
        .Par(s_Par), .par_oe(s_par_oe),
`endif
        .Stop(s_Stop)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (!be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_devsel"}, Devsel, 1);
        check({tag, "_trdy"}, Trdy, 1);
        check({tag, "_stop"}, Stop, 1);
        check({tag, "_oe"}, ad_oe, 0);
    endtask

    // One initiator transaction on the default-timing target, checked against the word model
    task automatic burst(input bit rd, input logic [31:0] addr, input int n, input int stall_idx, input bit hold);
        int  p, j, waitc;
        bit  stalled, last;
        Frame = 1; Irdy = 1; step();
        Frame = 0; CBE = rd ? 4'b0110 : 4'b0111; ad_in = addr; step();
        if (!((addr >= 32'h10) && (addr < 32'h30))) begin
            Irdy = 0; CBE = 4'h0; ad_in = $urandom;
            for (int c = 0; c < 4; c++) begin
                if (c == 3) Frame = 1;
                check_quiet("miss");
                step();
            end
            Irdy = 1; Frame = 1; step();
            return;
        end
        p = int'((addr - 32'h10) >> 2);
        check("devsel_k1", Devsel, 0);
        waitc = 0;
        while (Trdy !== 1'b0 && waitc < 8) begin
            if (rd) check("rd_oe_wait", ad_oe, (waitc > 0) ? 1 : 0);
            Irdy = 0; Frame = (n == 1 && !hold && stall_idx != 0); CBE = bv[0]; ad_in = wd[0];
            step();
            waitc++;
        end
        check("first_trdy_wait", waitc, rd ? 1 : 0);
        if (waitc >= 8) begin
            Frame = 1; Irdy = 1; step(); step();
            return;
        end
        j = 0; stalled = 0;
        while (j < 16) begin
            check("trdy_data", Trdy, 0);
            check("devsel_data", Devsel, 0);
            if (rd) check("rd_oe_data", ad_oe, 1);
            if (rd) check("rd_data", ad_out, model_mem[p]);
            if (j == stall_idx && !stalled) begin
                Irdy = 1; Frame = 0; stalled = 1;
                step();
                continue;
            end
            last = (j == n - 1) && !hold;
            Irdy = 0; Frame = last; CBE = bv[j];
            ad_in = rd ? 32'($urandom) : wd[j];
            if (rd) last_rd = ad_out;
            else model_mem[p] = merge(model_mem[p], wd[j], bv[j]);
            step();
            if (last) begin
                check_quiet("turn");
                break;
            end
            if (p == 7) begin
                for (int c = 0; c < 3; c++) begin
                    check("disc_stop", Stop, 0);
                    check("disc_trdy", Trdy, 1);
                    check("disc_devsel", Devsel, 0);
                    if (c == 2) Frame = 1;
                    step();
                end
                check_quiet("disc_turn");
                break;
            end
            p++; j++;
        end
        Irdy = 1; Frame = 1; CBE = 4'h0; step();
        check_quiet("post_idle");
    endtask

    initial begin
        int w, n, st;
        bit rd, hold;
        RST = 1; Frame = 1; Irdy = 1; CBE = 4'h0; ad_in = '0; last_rd = '0;
        step(); step();
        check_quiet("reset");
        check("reset_ad_out", ad_out, 0);
        check("reset_slow_devsel", s_Devsel, 1);
        RST = 0;

        // Fill the whole window, releasing Frame on the final word
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; bv[i] = 4'h0; end
        burst(0, 32'h10, 8, -1, 0);
        burst(1, 32'h10, 8, 3, 0);

        // Single write
        wd[0] = 32'h11111111; bv[0] = 4'h0;
        burst(0, 32'h14, 1, -1, 0);

        // Burst write with an Irdy stall, then burst read with a stall
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
        bv[0] = 4'h0; bv[1] = 4'h0; bv[2] = 4'h0;
        burst(0, 32'h14, 3, 1, 0);
        burst(1, 32'h14, 3, 1, 0);

        // Boundary disconnect then full readback
        wd[0] = $urandom; wd[1] = $urandom; wd[2] = $urandom;
        burst(0, 32'h2C, 3, -1, 1);
        burst(1, 32'h10, 8, -1, 0);

        // Randomized traffic
        for (int it = 0; it < 14; it++) begin
            rd = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 7);
            n  = $urandom_range(1, 4);
            if (w + n > 8) n = 8 - w;
            hold = (w + n == 8) && ($urandom_range(0, 1) == 1);
            st = $urandom_range(0, n) - 1;
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; bv[i] = 4'($urandom); end
            burst(rd, 32'h10 + 32'(4 * w), n, st, hold);
        end
        burst(1, 32'h10, 8, -1, 0);

        // Misses
        burst(0, 32'h40, 2, -1, 0);
        burst(1, 32'h0C, 1, -1, 0);
        burst(0, 32'h30, 1, -1, 0);

        // Byte enables
        wd[0] = 32'h11111111; bv[0] = 4'h0;
        burst(0, 32'h14, 1, -1, 0);
        wd[0] = 32'hAABBCCDD; bv[0] = 4'b1010;
        burst(0, 32'h14, 1, -1, 0);
        burst(1, 32'h14, 1, -1, 0);
        check("be_const", last_rd, 32'h11BB11DD);

        // Reset during the second data phase of a read burst
        Frame = 1; Irdy = 1; step();
        Frame = 0; CBE = 4'b0110; ad_in = 32'h10; step();
        Irdy = 0; CBE = 4'h0; step();
        step();
        check("mid_trdy_before_rst", Trdy, 0);
        RST = 1; step();
        check_quiet("mid_reset");
        RST = 0; Frame = 1; Irdy = 1; step();
        last_rd = '0;
        burst(1, 32'h14, 1, -1, 0);
        check("rst_readback", last_rd, 32'h11BB11DD);

        // Slow DEVSEL with one wait state on the second target
        RST = 1; step(); RST = 0;
        Frame = 1; Irdy = 1; step();
        Frame = 0; CBE = 4'b0111; ad_in = 32'h18; step();
        Frame = 1; Irdy = 0; CBE = 4'h0; ad_in = 32'h5A5A5A5A;
        model_mem[2] = 32'h5A5A5A5A;
        check("slow_k1_devsel", s_Devsel, 1);
        check("slow_k1_trdy", s_Trdy, 1);
        step();
        check("slow_k2_devsel", s_Devsel, 1);
        step();
        check("slow_k3_devsel", s_Devsel, 0);
        check("slow_k3_trdy", s_Trdy, 1);
        step();
        check("slow_k4_trdy", s_Trdy, 0);
        check("slow_k4_devsel", s_Devsel, 0);
        step();
        check("slow_turn_devsel", s_Devsel, 1);
        check("slow_turn_trdy", s_Trdy, 1);
        Irdy = 1; step();
        burst(1, 32'h18, 1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_burst_target.md
Name: pci_burst_target

Overview:
Parametrised PCI target (slave) with a local word memory. It supports single and burst memory read/write, per-byte enables, a configurable DEVSEL speed and initial wait states, and target disconnect at the memory boundary. It replaces the fixed-depth slave on the PCI side of the design. The AD bus is split into in/out/enable signals; the tri-state driver lives at the top level.

Parameters:
BASE_ADDR, 32'h0000_0010, byte base address of the target window (word aligned)
DEPTH, 8, number of 32-bit words in the target memory; window = BASE_ADDR .. BASE_ADDR+4*DEPTH-1
DEVSEL_DLY, 0, extra cycles before Devsel asserts (0 = fast, 1 = medium, 2 = slow)
WAIT_STATES, 0, extra cycles between Devsel assertion and the first Trdy

Ports:
Clock  input  1  bus clock; all state changes on the rising edge
RST  input  1  synchronous reset, active-high
Frame  input  1  active-low PCI FRAME#
Irdy  input  1  active-low initiator ready
CBE  input  4  command during the address phase; active-low byte enables during data phases
ad_in  input  32  sampled AD bus
ad_out  output  32  read data to the AD bus
ad_oe  output  1  AD output enable
Devsel  output  1  active-low device select
Trdy  output  1  active-low target ready
Stop  output  1  active-low stop (disconnect)
Par  output  1  even parity over AD and CBE (present only with PARITY_EN)
par_oe  output  1  Par output enable (present only with PARITY_EN)

Behaviour:
- Reset: RST=1 at an edge sets Devsel=1, Trdy=1, Stop=1, ad_oe=0, ad_out=0 and state IDLE. This applies at any point, including mid-burst. Memory contents are unaffected by reset.
- States: IDLE, ADDR_WAIT, DATA, DISC, TURN.
- Address phase: in IDLE, an edge with Frame=0 after a previous sample of Frame=1 and Irdy=1 is the address phase (cycle k).
  - Hit condition: CBE=4'b0110 (memory read) or 4'b0111 (memory write), and ad_in within the window.
  - Latch ptr = (ad_in-BASE_ADDR)>>2 and the direction.
  - On a miss, stay IDLE and ignore the bus until Frame=1 and Irdy=1 are both sampled.
- Devsel: asserted low from cycle k+1+DEVSEL_DLY and held until TURN.
- First Trdy cycle: F = k+1+DEVSEL_DLY+WAIT_STATES. For reads, F is at least k+2 (turnaround cycle). ADDR_WAIT counts the cycles until F.
- Read data path: ad_oe=1 from cycle k+2 until TURN. ad_out = mem[ptr], updated the edge after each transfer.
- Transfer: occurs at an edge in DATA with Irdy=0 and Trdy=0.
  - Write: for each i with CBE[i]=0, mem[ptr][8i+7:8i] <= ad_in[8i+7:8i].
  - Read: data is presented as above.
  - After a transfer, ptr increments.
  - Irdy=1 means no transfer; ptr and ad_out hold, and Trdy stays 0 (zero target wait states within a burst).
- Completion: a transfer with Frame=1 (last data phase) goes to TURN.
- Boundary: a transfer at ptr=DEPTH-1 with Frame=0 goes to DISC.
  - DISC drives Stop=0, Trdy=1, Devsel=0, and no further transfers occur.
  - DISC stays until Frame=1 is sampled, then goes to TURN.
- TURN: one cycle with Devsel=Trdy=Stop=1 and ad_oe=0, then IDLE.
- A new address phase is not accepted during TURN.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - For each read transfer, the cycle after the transfer drives Par = ^{ad_out,CBE} of that data phase with par_oe=1.
  - par_oe=1 from cycle k+3 until one cycle after the last read transfer.
  - On reset, Par=0 and par_oe=0.
- Undefined: the Par and par_oe ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single write: cmd 0111, addr 0x14, data 0x11111111, CBE=0000, Frame=1 in the data phase -> Devsel and Trdy low at k+1, mem[1]=0x11111111, TURN at k+2, IDLE after.
- Burst write then burst read at 0x14:
  - Write 0x11111111, 0x22222222, 0x33333333, with Irdy=1 for one cycle mid-burst -> mem[1..3] hold the three values.
  - Read (cmd 0110) -> ad_oe from k+2, first Trdy at k+2, the same three words in order, value held during the Irdy stall.
- Byte enables: mem[1]=0x11111111; write 0xAABBCCDD to 0x14 with CBE=4'b1010 -> mem[1]=0x11BB11DD.
- Boundary disconnect: burst write at 0x2C (word 7) with Frame held low -> exactly one transfer, then Stop=0 and Trdy=1 until Frame=1, then TURN; mem[0..6] unchanged.
- Miss and timing: addr 0x40 -> Devsel, Trdy and Stop stay 1 and ad_oe=0 throughout. With DEVSEL_DLY=2 and WAIT_STATES=1, a hit write shows Devsel at k+3 and Trdy at k+4.
- Reset mid-burst read: RST=1 during the second data phase -> next edge Devsel=Trdy=Stop=1 and ad_oe=0. A subsequent single read of 0x14 returns 0x11BB11DD.
